seq_match_monitor: RTL

//  Downstream consumer of the BBCCC detector's 1-cycle 'pattern' pulse.

---
 rtl/seq_match_monitor_if.sv | 29 ++
 rtl/seq_match_monitor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_match_monitor_if.sv
// Bus between the pattern detector / status logic and seq_match_monitor.
// The master drives the pulse, clear, threshold and ack.
// The slave returns the irq, busy flag and match statistics.
interface seq_match_monitor_if #(
  parameter int CNT_W    = 16,
  parameter int GAP_W    = 16,
  parameter int THRESH_W = 8
);
  logic                pattern;
  logic                clr;
  logic [THRESH_W-1:0] thresh;
  logic                irq_ack;
  logic                irq;
  logic                busy;
  logic [CNT_W-1:0]    match_cnt;
  logic                cnt_sat;
  logic [GAP_W-1:0]    last_gap;
  logic                gap_valid;

  modport master (
    output pattern, clr, thresh, irq_ack,
    input  irq, busy, match_cnt, cnt_sat, last_gap, gap_valid
  );

  modport slave (
    input  pattern, clr, thresh, irq_ack,
    output irq, busy, match_cnt, cnt_sat, last_gap, gap_valid
  );
endinterface

// File: rtl/seq_match_monitor.sv
// Match statistics and burst-alert monitor for the detector's 1-cycle pattern pulse.
// It keeps a saturating total count and the gap between the last two matches.
// It raises a sticky irq when T = max(thresh,1) matches land within a WIN-cycle window.
module seq_match_monitor #(
  parameter int CNT_W    = 16,
  parameter int GAP_W    = 16,
  parameter int THRESH_W = 8,
  parameter int WIN      = 64
) (
  input logic             clk,
  input logic             rst,
  seq_match_monitor_if.slave bus
);
  localparam int WIN_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_ALERT} state_t;

  state_t              r_state, w_nxt;
  logic [THRESH_W-1:0] r_burst, w_burst_nxt;
  logic [WIN_W-1:0]    r_win, w_win_nxt;
  logic                w_open;
  logic [THRESH_W-1:0] w_t;
  logic [THRESH_W:0]   w_burst_inc;

  logic                r_irq, r_busy;
  logic [CNT_W-1:0]    r_match_cnt;
  logic                r_cnt_sat;
  logic [GAP_W-1:0]    r_gap_cnt, r_last_gap;
  logic                r_gap_run, r_gap_valid;

  assign w_t         = (bus.thresh == '0) ? THRESH_W'(1) : bus.thresh;
  assign w_burst_inc = {1'b0, r_burst} + (THRESH_W+1)'(1);

  // Next state, burst count and window age. Window expiry is resolved one
  // cycle late (r_win == WIN) so a pulse at t+WIN opens a fresh window with
  // busy held high throughout.
  always_comb begin
    w_nxt       = r_state;
    w_burst_nxt = r_burst;
    w_win_nxt   = r_win;
    w_open      = 1'b0;
    if (bus.clr) begin
      w_nxt       = S_IDLE;
      w_burst_nxt = '0;
      w_win_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pattern) w_open = 1'b1;
        end
        S_WINDOW: begin
          if (r_win >= WIN_W'(WIN)) begin
            if (bus.pattern) w_open = 1'b1;
            else begin
              w_nxt       = S_IDLE;
              w_burst_nxt = '0;
              w_win_nxt   = '0;
            end
          end else begin
            w_win_nxt = r_win + WIN_W'(1);
            if (bus.pattern) begin
              w_burst_nxt = w_burst_inc[THRESH_W-1:0];
              if (w_burst_inc >= {1'b0, w_t}) w_nxt = S_ALERT;
            end
          end
        end
        S_ALERT: begin
          if (bus.irq_ack) begin
            if (bus.pattern) w_open = 1'b1;
            else begin
              w_nxt       = S_IDLE;
              w_burst_nxt = '0;
              w_win_nxt   = '0;
            end
          end
        end
        default: begin
          w_nxt       = S_IDLE;
          w_burst_nxt = '0;
          w_win_nxt   = '0;
        end
      endcase
      if (w_open) begin
        w_burst_nxt = THRESH_W'(1);
        w_win_nxt   = WIN_W'(1);
        w_nxt       = (w_t == THRESH_W'(1)) ? S_ALERT : S_WINDOW;
      end
    end
  end

  // FSM state, burst counter and window age registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_burst <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_nxt;
      r_burst <= w_burst_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // Registered irq/busy, taken from the next state so they track the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_irq  <= (w_nxt == S_ALERT);
      r_busy <= (w_nxt != S_IDLE);
    end
  end

  // Saturating total match count with a sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
      r_cnt_sat   <= 1'b0;
    end else if (bus.clr) begin
      r_match_cnt <= '0;
      r_cnt_sat   <= 1'b0;
    end else if (bus.pattern) begin
      if (r_match_cnt != CNT_MAX) r_match_cnt <= r_match_cnt + CNT_W'(1);
      if (r_match_cnt >= CNT_MAX - CNT_W'(1)) r_cnt_sat <= 1'b1;
    end
  end

  // Gap measurement. The counter runs from the first match and saturates.
  // Each later match latches the gap and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt   <= '0;
      r_gap_run   <= 1'b0;
      r_last_gap  <= '0;
      r_gap_valid <= 1'b0;
    end else if (bus.clr) begin
      r_gap_cnt   <= '0;
      r_gap_run   <= 1'b0;
      r_last_gap  <= '0;
      r_gap_valid <= 1'b0;
    end else if (bus.pattern) begin
      if (r_gap_run) begin
        r_last_gap  <= r_gap_cnt;
        r_gap_valid <= 1'b1;
      end
      r_gap_run <= 1'b1;
      r_gap_cnt <= GAP_W'(1);
    end else if (r_gap_run && r_gap_cnt != GAP_MAX) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  assign bus.irq       = r_irq;
  assign bus.busy      = r_busy;
  assign bus.match_cnt = r_match_cnt;
  assign bus.cnt_sat   = r_cnt_sat;
  assign bus.last_gap  = r_last_gap;
  assign bus.gap_valid = r_gap_valid;
endmodule
